mem_arbiter: RTL and testbench

//   Two-master round-robin arbiter that shares one memory port (enable/write/ready/addr/data)

---
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter sharing one memory port; each access runs
// IDLE -> ACCESS -> DONE with a registered result and a one-cycle ack to its owner.
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  m0_req,
    input  logic                  m0_write,
    input  logic [DATA_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ack,
    output logic                  m0_err,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_write,
    input  logic [DATA_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  mem_enable,
    output logic                  mem_write,
    input  logic                  mem_ready,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [1:0]            state_q, state_d;
    logic                  last_q, last_d;     // 1 = m1 was granted last
    logic                  owner_q, owner_d;
    logic                  write_q, write_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  gnt;
    logic                  in_acc, in_done;

    // Tie goes to whoever was not served last; otherwise the lone requester wins.
    assign gnt = (m0_req && m1_req) ? ~last_q : m1_req;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        write_d = write_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    state_d = S_ACCESS;
                    owner_d = gnt;
                    last_d  = gnt;
                    write_d = gnt ? m1_write : m0_write;
                    addr_d  = gnt ? m1_addr  : m0_addr;
                    wdata_d = gnt ? m1_wdata : m0_wdata;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    rdata_d = '0;
                end
            end
            S_ACCESS: begin
                // X/Z on ready must never complete an access.
                if (mem_ready === 1'b1) begin
                    rdata_d = write_q ? '0 : mem_rdata;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            write_q <= write_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_acc  = (state_q == S_ACCESS);
    assign in_done = (state_q == S_DONE);

    assign mem_enable = in_acc;
    assign mem_write  = in_acc & write_q;
    assign mem_addr   = in_acc ? addr_q  : '0;
    assign mem_wdata  = in_acc ? wdata_q : '0;

    assign m0_ack   = in_done & ~owner_q;
    assign m1_ack   = in_done &  owner_q;
    assign m0_err   = m0_ack & err_q;
    assign m1_err   = m1_ack & err_q;
    assign m0_rdata = m0_ack ? rdata_q : '0;
    assign m1_rdata = m1_ack ? rdata_q : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter against a transaction-level
// model: grant by round-robin rule, reference memory, latency and timeout arithmetic.
module tb_mem_arbiter;
    localparam int DW = 32;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_req, m0_write, m1_req, m1_write;
    logic [DW-1:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic          m0_ack, m0_err, m1_ack, m1_err;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          mem_enable, mem_write, mem_ready;
    logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] env_mem [256];
    logic [31:0] ref_mem [256];
    logic        mem_init = 1'b1;
    int          rdy_dly = 0;
    int          en_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    bit          last_g = 1'b1;
    bit          at_done = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk_in(clk), .rst_in(rst),
        .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .mem_enable(mem_enable), .mem_write(mem_write), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_val(int i);
        if (i == 16) return 32'hDEADBEEF;
        return (32'(i) * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    // Memory device: ready comes after rdy_dly enable cycles, X while waiting, Z when idle.
    always_comb mem_ready = mem_enable ? ((en_cnt >= rdy_dly) ? 1'b1 : 1'bx) : 1'bz;
    always_comb mem_rdata = mem_enable ? env_mem[mem_addr[7:0]] : 32'h0;

    always @(posedge clk) begin
        en_cnt <= mem_enable ? en_cnt + 1 : 0;
        if (mem_init) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= init_val(i);
        end else if (mem_enable && mem_write && mem_ready === 1'b1) begin
            env_mem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit pick(bit r0, bit r1, bit last);
        if (r0 && r1) return !last;
        return r1;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        at_done = 1'b0;
    endtask

    // Runs one transaction to its ack and checks it against the model.
    task automatic wait_ack(input int dly, input bit chg, input bit drop);
        bit w, ew, eto, got, got_m1;
        logic [31:0] ea, ed, erd;
        int lat, n, en_s, wr_s, cm_s;
        got = 0; got_m1 = 0; n = 0; en_s = 0; wr_s = 0; cm_s = 0;
        w   = pick(m0_req, m1_req, last_g);
        ew  = w ? m1_write : m0_write;
        ea  = w ? m1_addr  : m0_addr;
        ed  = w ? m1_wdata : m0_wdata;
        eto = (dly >= TO);
        lat = (at_done ? 3 : 2) + (eto ? TO - 1 : dly);
        erd = (eto || ew) ? 32'h0 : ref_mem[ea[7:0]];
        if (!eto && ew) ref_mem[ea[7:0]] = ed;
        last_g  = w;
        rdy_dly = dly;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            if (chg && mem_enable && m0_req) begin
                m0_req  = 1'b0;
                m0_addr = ~m0_addr;
            end
            if (mem_enable) begin
                en_s++;
                chk("mem_addr", mem_addr, ea);
                chk("mem_write", 32'(mem_write), 32'(ew));
                chk("mem_wdata", mem_wdata, ed);
                if (mem_write) wr_s++;
                if (mem_write && mem_ready === 1'b1) cm_s++;
            end
            if (m0_ack || m1_ack) begin
                got    = 1;
                got_m1 = m1_ack;
            end
        end
        chk("ack_seen", 32'(got), 32'd1);
        chk("ack_cycle", 32'(n), 32'(lat));
        chk("ack_owner", 32'(got_m1), 32'(w));
        chk("other_ack", 32'(w ? m0_ack : m1_ack), 32'd0);
        chk("rdata", w ? m1_rdata : m0_rdata, erd);
        chk("err", 32'(w ? m1_err : m0_err), 32'(eto));
        chk("en_cycles", 32'(en_s), 32'(eto ? TO : dly + 1));
        chk("wr_cycles", 32'(wr_s), 32'(ew ? (eto ? TO : dly + 1) : 0));
        chk("commits", 32'(cm_s), 32'((ew && !eto) ? 1 : 0));
        if (drop) begin
            if (w) m1_req = 1'b0;
            else   m0_req = 1'b0;
        end
        at_done = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_g = 1'b1;
        idle(1);
    endtask

    initial begin
        int dly, r;
        m0_req = 0; m0_write = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_write = 0; m1_addr = 0; m1_wdata = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        repeat (2) @(negedge clk);
        chk("rst_enable", 32'(mem_enable), 32'd0);
        chk("rst_write", 32'(mem_write), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_acks", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
        chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
        rst = 1'b0;
        mem_init = 1'b0;
        idle(1);

        // m0 read of preloaded word
        m0_req = 1; m0_write = 0; m0_addr = 32'h10;
        wait_ack(0, 0, 1);

        // m1 write then read back, back-to-back from DONE
        m1_req = 1; m1_write = 1; m1_addr = 32'h20; m1_wdata = 32'h12345678;
        wait_ack(0, 0, 1);
        m1_req = 1; m1_write = 0;
        wait_ack(0, 0, 1);
        idle(2);

        // both held from reset: strict alternation, fields never cross
        do_reset();
        m0_req = 1; m0_write = 0; m0_addr = 32'h30; m0_wdata = 32'hAAAA0000;
        m1_req = 1; m1_write = 1; m1_addr = 32'h40; m1_wdata = 32'h5555FFFF;
        for (int k = 0; k < 4; k++) wait_ack(0, 0, 0);
        chk("alternate_last", 32'(last_g), 32'd1);
        m0_req = 0; m1_req = 0;
        idle(2);

        // ready never arrives, then the one-short boundary that just completes
        m0_req = 1; m0_write = 0; m0_addr = 32'h44;
        wait_ack(100, 0, 1);
        idle(1);
        chk("idle_after_to", 32'(mem_enable), 32'd0);
        m1_req = 1; m1_write = 1; m1_addr = 32'h45; m1_wdata = 32'hCAFEF00D;
        wait_ack(TO - 1, 0, 1);
        idle(1);

        // reset mid-access by m0; pointer must return to favour m0
        m0_req = 1; m0_write = 0; m0_addr = 32'h50; rdy_dly = 10;
        repeat (3) @(negedge clk);
        chk("pre_rst_enable", 32'(mem_enable), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_enable", 32'(mem_enable), 32'd0);
        chk("mid_rst_write", 32'(mem_write), 32'd0);
        chk("mid_rst_acks", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
        m0_req = 0;
        @(negedge clk);
        rst = 1'b0;
        last_g = 1'b1;
        idle(1);
        m0_req = 1; m0_addr = 32'h51;
        m1_req = 1; m1_write = 0; m1_addr = 32'h52;
        wait_ack(0, 0, 1);
        wait_ack(1, 0, 1);
        idle(2);

        // m0 abandons req and changes addr mid-access
        m0_req = 1; m0_write = 0; m0_addr = 32'h60;
        wait_ack(3, 1, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("no_second_ack", 32'({m0_ack, m1_ack}), 32'd0);
        end
        at_done = 1'b0;

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            if (!m0_req && $urandom_range(1) == 1) begin
                m0_req = 1; m0_write = 1'($urandom_range(1));
                m0_addr = 32'($urandom_range(255)); m0_wdata = $urandom;
            end
            if (!m1_req && $urandom_range(1) == 1) begin
                m1_req = 1; m1_write = 1'($urandom_range(1));
                m1_addr = 32'($urandom_range(255)); m1_wdata = $urandom;
            end
            if (!m0_req && !m1_req) begin
                m0_req = 1; m0_write = 0; m0_addr = 32'($urandom_range(255));
            end
            r = int'($urandom_range(9));
            if (r == 9)      dly = TO + int'($urandom_range(3));
            else if (r == 8) dly = TO - 1;
            else             dly = r % 4;
            wait_ack(dly, 0, 1);
        end
        if (m0_req || m1_req) wait_ack(0, 0, 1);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
